// File: rtl/eigen_pkg.sv
// Shared types for the eigen engine scheduler: payload widths, bus types, FSM states.
package eigen_pkg;

  localparam int unsigned IN_BYTES  = 4;
  localparam int unsigned OUT_BYTES = 12;
  localparam int unsigned IN_W      = IN_BYTES * 8;
  localparam int unsigned OUT_W     = OUT_BYTES * 8;

  typedef logic [IN_W-1:0]  mat_in_t;
  typedef logic [OUT_W-1:0] eig_out_t;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ISSUE,
    S_WAIT,
    S_DELIVER,
    S_FLUSH
  } state_t;

  // Saturating increment for the 8-bit timeout counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    return (v == 8'hFF) ? v : v + 8'd1;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Round-robin pick: first requester after 'last' (wrapping) with req set.
module rr_arbiter #(
  parameter  int unsigned N  = 4,
  localparam int unsigned IW = $clog2(N)
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] last,
  output logic [N-1:0]  gnt,
  output logic [IW-1:0] idx,
  output logic          any
);

  always_comb begin
    logic [31:0] cand;
    cand = '0;
    gnt  = '0;
    idx  = '0;
    any  = 1'b0;
    for (int unsigned i = 1; i <= N; i++) begin
      cand = (32'(last) + i) % N;
      if (!any && req[IW'(cand)]) begin
        any              = 1'b1;
        idx              = IW'(cand);
        gnt[IW'(cand)]   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/eigen_sched.sv
// Shares one 2x2 eigen engine among NUM_REQ requesters with round-robin arbitration.
// Optional engine timeout/flush recovery is enabled by defining EIGEN_SCHED_TIMEOUT_EN.
module eigen_sched
  import eigen_pkg::*;
#(
  parameter  int unsigned NUM_REQ     = 4,
  parameter  int unsigned TIMEOUT_CYC = 64,
  localparam int unsigned GW          = $clog2(NUM_REQ)
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NUM_REQ-1:0]   req_valid,
  input  mat_in_t [NUM_REQ-1:0] req_data,
  output logic [NUM_REQ-1:0]   req_ready,
  output logic [NUM_REQ-1:0]   rsp_valid,
  input  logic [NUM_REQ-1:0]   rsp_ready,
  output eig_out_t             rsp_data,
  output logic                 rsp_err,
  output mat_in_t              eng_axiid,
  output logic                 eng_axiiv,
  input  eig_out_t             eng_axiod,
  input  logic                 eng_axiov,
  output logic                 eng_rst,
  output logic                 busy,
  output logic [GW-1:0]        grant_id,
  output logic [7:0]           timeout_cnt
);

  if (NUM_REQ < 2 || NUM_REQ > 8 || TIMEOUT_CYC < 4 || TIMEOUT_CYC > 1023) begin : g_bad_param
    $error("eigen_sched: parameter out of range");
  end

  state_t               state;
  logic [GW-1:0]        last_grant;
  logic [NUM_REQ-1:0]   arb_gnt;
  logic [GW-1:0]        arb_idx;
  logic                 arb_any;
  logic [NUM_REQ-1:0]   owner_oh;

  assign owner_oh = NUM_REQ'(1) << grant_id;

  rr_arbiter #(.N(NUM_REQ)) u_arb (
    .req  (req_valid),
    .last (last_grant),
    .gnt  (arb_gnt),
    .idx  (arb_idx),
    .any  (arb_any)
  );

`ifdef EIGEN_SCHED_TIMEOUT_EN
  localparam int unsigned CW = $clog2(TIMEOUT_CYC);
  logic [CW-1:0] wait_cnt;
  logic          flush_cnt;
  logic          eng_rst_q;
  logic          rsp_err_q;
  logic [7:0]    timeout_cnt_q;

  assign eng_rst     = eng_rst_q;
  assign rsp_err     = rsp_err_q;
  assign timeout_cnt = timeout_cnt_q;
`else
  // Without recovery the engine is only reset alongside the scheduler.
  assign eng_rst     = ~rst_n;
  assign rsp_err     = 1'b0;
  assign timeout_cnt = '0;
`endif

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state      <= S_IDLE;
      req_ready  <= '0;
      rsp_valid  <= '0;
      eng_axiiv  <= 1'b0;
      busy       <= 1'b0;
      rsp_data   <= '0;
      eng_axiid  <= '0;
      grant_id   <= '0;
      last_grant <= GW'(NUM_REQ - 1);
`ifdef EIGEN_SCHED_TIMEOUT_EN
      wait_cnt      <= '0;
      flush_cnt     <= 1'b0;
      eng_rst_q     <= 1'b1;
      rsp_err_q     <= 1'b0;
      timeout_cnt_q <= '0;
`endif
    end else begin
      req_ready <= '0;
      eng_axiiv <= 1'b0;
`ifdef EIGEN_SCHED_TIMEOUT_EN
      eng_rst_q <= 1'b0;
`endif
      case (state)
        S_IDLE: begin
          if (arb_any) begin
            req_ready <= arb_gnt;
            eng_axiid <= req_data[arb_idx];
            grant_id  <= arb_idx;
            eng_axiiv <= 1'b1;
            busy      <= 1'b1;
            state     <= S_ISSUE;
          end
        end
        S_ISSUE: begin
`ifdef EIGEN_SCHED_TIMEOUT_EN
          wait_cnt <= '0;
`endif
          state <= S_WAIT;
        end
        S_WAIT: begin
          if (eng_axiov) begin
            rsp_data  <= eng_axiod;
            rsp_valid <= owner_oh;
`ifdef EIGEN_SCHED_TIMEOUT_EN
            rsp_err_q <= 1'b0;
`endif
            state     <= S_DELIVER;
          end
`ifdef EIGEN_SCHED_TIMEOUT_EN
          else if (wait_cnt == CW'(TIMEOUT_CYC - 1)) begin
            rsp_data      <= '0;
            rsp_err_q     <= 1'b1;
            timeout_cnt_q <= sat_inc8(timeout_cnt_q);
            eng_rst_q     <= 1'b1;
            flush_cnt     <= 1'b0;
            state         <= S_FLUSH;
          end else begin
            wait_cnt <= wait_cnt + CW'(1);
          end
`endif
        end
`ifdef EIGEN_SCHED_TIMEOUT_EN
        // Hold the engine in reset for two cycles so a hung job is discarded.
        S_FLUSH: begin
          if (flush_cnt) begin
            rsp_valid <= owner_oh;
            state     <= S_DELIVER;
          end else begin
            eng_rst_q <= 1'b1;
            flush_cnt <= 1'b1;
          end
        end
`endif
        S_DELIVER: begin
          if (rsp_ready[grant_id]) begin
            rsp_valid  <= '0;
            last_grant <= grant_id;
            busy       <= 1'b0;
            state      <= S_IDLE;
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_eigen_sched.sv
// Directed self-checking bench for eigen_sched; timeout scenario follows EIGEN_SCHED_TIMEOUT_EN.
module tb_eigen_sched;
  import eigen_pkg::*;

  localparam int unsigned NR = 4;
  localparam int unsigned TO = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NR-1:0] req_valid;
  mat_in_t [NR-1:0] req_data;
  logic [NR-1:0] req_ready;
  logic [NR-1:0] rsp_valid;
  logic [NR-1:0] rsp_ready;
  eig_out_t      rsp_data;
  logic          rsp_err;
  mat_in_t       eng_axiid;
  logic          eng_axiiv;
  eig_out_t      eng_axiod;
  logic          eng_axiov;
  logic          eng_rst;
  logic          busy;
  logic [1:0]    grant_id;
  logic [7:0]    timeout_cnt;

  int checks = 0;
  int errors = 0;

  // Engine model: automatic responder plus manual override used by the bench.
  logic     eng_auto  = 1'b1;
  int       eng_delay = 5;
  mat_in_t  eng_cap;
  logic     auto_v = 1'b0;
  eig_out_t auto_d = '0;
  logic     man_v  = 1'b0;
  eig_out_t man_d  = '0;

  assign eng_axiov = auto_v | man_v;
  assign eng_axiod = man_v ? man_d : auto_d;

  always #5 clk = ~clk;

  eigen_sched #(.NUM_REQ(NR), .TIMEOUT_CYC(TO)) dut (
    .clk(clk), .rst_n(rst_n), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_err(rsp_err), .eng_axiid(eng_axiid),
    .eng_axiiv(eng_axiiv), .eng_axiod(eng_axiod), .eng_axiov(eng_axiov),
    .eng_rst(eng_rst), .busy(busy), .grant_id(grant_id), .timeout_cnt(timeout_cnt)
  );

  function automatic eig_out_t model_out(input mat_in_t m);
    return {m, ~m, m ^ 32'hA5A5_A5A5};
  endfunction

  always @(negedge clk) begin
    if (eng_auto && eng_axiiv) begin
      eng_cap = eng_axiid;
      repeat (eng_delay) @(negedge clk);
      auto_d = model_out(eng_cap);
      auto_v = 1'b1;
      @(negedge clk);
      auto_v = 1'b0;
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Return to IDLE with nothing pending; ok=0 if the scheduler never settles.
  task automatic drain(output bit ok);
    req_valid = '0;
    rsp_ready = '1;
    ok = 1'b0;
    for (int c = 0; c < 60 && !ok; c++) begin
      step();
      if (!busy && rsp_valid == '0) ok = 1'b1;
    end
    rsp_ready = '0;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    req_valid = '0;
    rsp_ready = '0;
    req_data = '0;
    repeat (2) step();
    checks++;
    if ({req_ready, rsp_valid, eng_axiiv, busy, rsp_err, eng_rst, grant_id, timeout_cnt} !==
        {4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b0, 8'b0}) begin
      errors++;
      $display("FAIL reset_ctrl: got rr=%b rv=%b iv=%b busy=%b err=%b erst=%b gid=%0d tc=%0d",
               req_ready, rsp_valid, eng_axiiv, busy, rsp_err, eng_rst, grant_id, timeout_cnt);
    end
    checks++;
    if (rsp_data !== '0 || eng_axiid !== '0) begin
      errors++;
      $display("FAIL reset_data: got rsp_data=%h eng_axiid=%h expected 0", rsp_data, eng_axiid);
    end
    rst_n = 1'b1;
    step();
    checks++;
    if (eng_rst !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: got eng_rst=%b busy=%b expected 0 0", eng_rst, busy);
    end
  endtask

  task automatic test_single();
    eig_out_t exp_d;
    req_data[0] = 32'h0100_0001;
    exp_d = model_out(32'h0100_0001);
    req_valid = 4'b0001;
    step();
    checks++;
    if ({req_ready, eng_axiiv, busy, grant_id} !== {4'b0001, 1'b1, 1'b1, 2'd0}) begin
      errors++;
      $display("FAIL single_grant: got rr=%b iv=%b busy=%b gid=%0d expected 0001 1 1 0",
               req_ready, eng_axiiv, busy, grant_id);
    end
    checks++;
    if (eng_axiid !== 32'h0100_0001) begin
      errors++;
      $display("FAIL single_axiid: got %h expected 01000001", eng_axiid);
    end
    req_valid = '0;
    step();
    checks++;
    if ({req_ready, eng_axiiv} !== 5'b0) begin
      errors++;
      $display("FAIL single_issue_pulse: got rr=%b iv=%b expected 0000 0", req_ready, eng_axiiv);
    end
    repeat (4) step();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL single_early_rsp: got %b expected 0000", rsp_valid);
    end
    step();
    checks++;
    if (rsp_valid !== 4'b0001 || eng_axiov !== 1'b1) begin
      errors++;
      $display("FAIL single_rsp_latency: got rsp_valid=%b axiov=%b expected 0001 1", rsp_valid, eng_axiov);
    end
    checks++;
    if (rsp_data !== exp_d || rsp_err !== 1'b0) begin
      errors++;
      $display("FAIL single_rsp_data: got %h err=%b expected %h err=0", rsp_data, rsp_err, exp_d);
    end
    rsp_ready = 4'b0001;
    step();
    checks++;
    if (rsp_valid !== 4'b0000 || busy !== 1'b0) begin
      errors++;
      $display("FAIL single_consume: got rsp_valid=%b busy=%b expected 0000 0", rsp_valid, busy);
    end
    rsp_ready = '0;
  endtask

  task automatic test_fairness();
    int exp_order[5] = '{0, 1, 2, 3, 0};
    bit ok;
    rst_n = 1'b0;
    step();
    rst_n = 1'b1;
    for (int i = 0; i < 4; i++) req_data[i] = mat_in_t'(32'h1111_1111 * (i + 1));
    req_valid = 4'hF;
    rsp_ready = 4'hF;
    for (int k = 0; k < 5; k++) begin
      ok = 1'b0;
      for (int c = 0; c < 40 && !ok; c++) begin
        step();
        if (req_ready != '0) ok = 1'b1;
      end
      checks++;
      if (!ok || req_ready !== 4'(1 << exp_order[k]) || grant_id !== 2'(exp_order[k])) begin
        errors++;
        $display("FAIL fair_grant%0d: got rr=%b gid=%0d expected requester %0d",
                 k, req_ready, grant_id, exp_order[k]);
      end
      checks++;
      if (eng_axiid !== mat_in_t'(32'h1111_1111 * (exp_order[k] + 1))) begin
        errors++;
        $display("FAIL fair_axiid%0d: got %h", k, eng_axiid);
      end
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL fair_drain: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_backpressure();
    eig_out_t exp_d;
    bit ok;
    bit stable;
    req_data[2] = 32'hDEAD_BEEF;
    exp_d = model_out(32'hDEAD_BEEF);
    req_valid = 4'b0100;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      step();
      if (req_ready != '0) ok = 1'b1;
    end
    checks++;
    if (!ok || req_ready !== 4'b0100) begin
      errors++;
      $display("FAIL bp_grant: got %b expected 0100", req_ready);
    end
    req_valid = 4'b1011;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      step();
      if (rsp_valid != '0) ok = 1'b1;
    end
    // Non-owners raising rsp_ready must not release the result.
    rsp_ready = 4'b1011;
    stable = ok;
    for (int c = 0; c < 10; c++) begin
      step();
      if (rsp_valid !== 4'b0100 || rsp_data !== exp_d || eng_axiiv !== 1'b0 || req_ready !== 4'b0)
        stable = 1'b0;
    end
    checks++;
    if (!stable) begin
      errors++;
      $display("FAIL bp_hold: got rsp_valid=%b rsp_data=%h iv=%b expected 0100 %h 0",
               rsp_valid, rsp_data, eng_axiiv, exp_d);
    end
    rsp_ready = 4'b0100;
    step();
    checks++;
    if (rsp_valid !== 4'b0000) begin
      errors++;
      $display("FAIL bp_release: got %b expected 0000", rsp_valid);
    end
    rsp_ready = '0;
    step();
    checks++;
    if (req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL bp_next_grant: got %b expected 1000", req_ready);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL bp_drain: got busy=%b expected 0", busy);
    end
  endtask

  task automatic test_drop();
    bit ok;
    req_valid = 4'b0001;
    step();
    checks++;
    if (req_ready !== 4'b0001) begin
      errors++;
      $display("FAIL drop_first: got %b expected 0001", req_ready);
    end
    req_valid = 4'b0100;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      step();
      if (rsp_valid != '0) ok = 1'b1;
    end
    req_valid = 4'b1000;
    rsp_ready = 4'b0001;
    step();
    rsp_ready = '0;
    step();
    checks++;
    if (!ok || req_ready !== 4'b1000) begin
      errors++;
      $display("FAIL drop_no_grant: got %b expected 1000", req_ready);
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL drop_drain: got busy=%b expected 0", busy);
    end
  endtask

`ifdef EIGEN_SCHED_TIMEOUT_EN
  task automatic test_timeout();
    bit quiet;
    eng_auto = 1'b0;
    req_data[1] = 32'h0203_0405;
    req_valid = 4'b0010;
    step();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL to_grant: got %b expected 0010", req_ready);
    end
    req_valid = '0;
    quiet = 1'b1;
    repeat (TO) begin
      step();
      if (eng_rst !== 1'b0 || rsp_valid !== 4'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL to_wait: got eng_rst=%b rsp_valid=%b expected 0 0000", eng_rst, rsp_valid);
    end
    step();
    checks++;
    if ({eng_rst, rsp_err, rsp_valid, timeout_cnt} !== {1'b1, 1'b1, 4'b0, 8'd1} || rsp_data !== '0) begin
      errors++;
      $display("FAIL to_flush_enter: got erst=%b err=%b rv=%b tc=%0d data=%h expected 1 1 0000 1 0",
               eng_rst, rsp_err, rsp_valid, timeout_cnt, rsp_data);
    end
    man_d = '1;
    man_v = 1'b1;
    step();
    checks++;
    if (eng_rst !== 1'b1 || rsp_valid !== 4'b0) begin
      errors++;
      $display("FAIL to_flush_2nd: got eng_rst=%b rsp_valid=%b expected 1 0000", eng_rst, rsp_valid);
    end
    man_v = 1'b0;
    step();
    checks++;
    if ({eng_rst, rsp_valid, rsp_err} !== {1'b0, 4'b0010, 1'b1} || rsp_data !== '0) begin
      errors++;
      $display("FAIL to_deliver: got erst=%b rv=%b err=%b data=%h expected 0 0010 1 0",
               eng_rst, rsp_valid, rsp_err, rsp_data);
    end
    man_v = 1'b1;
    step();
    man_v = 1'b0;
    checks++;
    if (rsp_data !== '0 || rsp_valid !== 4'b0010 || timeout_cnt !== 8'd1) begin
      errors++;
      $display("FAIL to_late_ignored: got data=%h rv=%b tc=%0d expected 0 0010 1", rsp_data, rsp_valid, timeout_cnt);
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    checks++;
    if (rsp_valid !== 4'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL to_consume: got rv=%b busy=%b expected 0000 0", rsp_valid, busy);
    end
    eng_auto = 1'b1;
  endtask
`else
  task automatic test_no_timeout();
    bit quiet;
    eng_auto = 1'b0;
    req_valid = 4'b0010;
    step();
    checks++;
    if (req_ready !== 4'b0010) begin
      errors++;
      $display("FAIL nto_grant: got %b expected 0010", req_ready);
    end
    req_valid = '0;
    quiet = 1'b1;
    repeat (500) begin
      step();
      if (busy !== 1'b1 || rsp_valid !== 4'b0 || rsp_err !== 1'b0 || eng_rst !== 1'b0) quiet = 1'b0;
    end
    checks++;
    if (!quiet) begin
      errors++;
      $display("FAIL nto_wait: got busy=%b rv=%b err=%b erst=%b expected 1 0000 0 0",
               busy, rsp_valid, rsp_err, eng_rst);
    end
    man_d = model_out(32'h0A0B_0C0D);
    man_v = 1'b1;
    step();
    man_v = 1'b0;
    checks++;
    if (rsp_valid !== 4'b0010 || rsp_data !== model_out(32'h0A0B_0C0D) || timeout_cnt !== 8'd0) begin
      errors++;
      $display("FAIL nto_late_rsp: got rv=%b data=%h tc=%0d", rsp_valid, rsp_data, timeout_cnt);
    end
    rsp_ready = 4'b0010;
    step();
    rsp_ready = '0;
    checks++;
    if (busy !== 1'b0) begin
      errors++;
      $display("FAIL nto_consume: got busy=%b expected 0", busy);
    end
    eng_auto = 1'b1;
  endtask
`endif

  task automatic test_reset_mid_wait();
    bit ok;
    eng_auto = 1'b0;
    req_data[0] = 32'h0707_0707;
    req_valid = 4'b0001;
    repeat (4) step();
    checks++;
    if (busy !== 1'b1 || eng_axiid !== 32'h0707_0707) begin
      errors++;
      $display("FAIL rmw_in_wait: got busy=%b axiid=%h expected 1 07070707", busy, eng_axiid);
    end
    rst_n = 1'b0;
    #1;
    checks++;
    if ({req_ready, rsp_valid, eng_axiiv, busy, rsp_err, eng_rst, grant_id, timeout_cnt} !==
        {4'b0, 4'b0, 1'b0, 1'b0, 1'b0, 1'b1, 2'b0, 8'b0}) begin
      errors++;
      $display("FAIL rmw_ctrl: got rr=%b rv=%b iv=%b busy=%b err=%b erst=%b gid=%0d tc=%0d",
               req_ready, rsp_valid, eng_axiiv, busy, rsp_err, eng_rst, grant_id, timeout_cnt);
    end
    checks++;
    if (rsp_data !== '0 || eng_axiid !== '0) begin
      errors++;
      $display("FAIL rmw_data: got rsp_data=%h eng_axiid=%h expected 0", rsp_data, eng_axiid);
    end
    step();
    eng_auto = 1'b1;
    req_data[1] = 32'h1234_5678;
    req_valid = 4'b0110;
    rst_n = 1'b1;
    step();
    checks++;
    if (req_ready !== 4'b0010 || grant_id !== 2'd1) begin
      errors++;
      $display("FAIL rmw_first_grant: got rr=%b gid=%0d expected 0010 1", req_ready, grant_id);
    end
    req_valid = '0;
    ok = 1'b0;
    for (int c = 0; c < 20 && !ok; c++) begin
      step();
      if (rsp_valid != '0) ok = 1'b1;
    end
    checks++;
    if (!ok || rsp_valid !== 4'b0010 || rsp_data !== model_out(32'h1234_5678)) begin
      errors++;
      $display("FAIL rmw_rsp: got rv=%b data=%h expected 0010 %h", rsp_valid, rsp_data, model_out(32'h1234_5678));
    end
    drain(ok);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL rmw_drain: got busy=%b expected 0", busy);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_fairness();
    test_backpressure();
    test_drop();
`ifdef EIGEN_SCHED_TIMEOUT_EN
    test_timeout();
`else
    test_no_timeout();
`endif
    test_reset_mid_wait();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
